// File: rtl/tt_mux_pkg.sv
// ----------------------------------------------------------------------------
// tt_mux_pkg
// Shared definitions for the project multiplexer controller:
//   state_t    - controller state encoding (IDLE, OFF, ARM, RUN)
//   IW_W       - width of the host-to-project input bus
//   OW_W       - width of one project's output slice
//   OFF_CYCLES - cycles with every project disabled before arming a new one
//   CNT_W      - width of the phase counter shared by OFF and ARM
// ----------------------------------------------------------------------------
package tt_mux_pkg;

   localparam int unsigned IW_W       = 18;
   localparam int unsigned OW_W       = 24;
   localparam int unsigned OFF_CYCLES = 2;
   localparam int unsigned CNT_W      = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OFF  = 2'd1,
      ST_ARM  = 2'd2,
      ST_RUN  = 2'd3
   } state_t;

endpackage : tt_mux_pkg

// File: rtl/tt_mux_ow_sel.sv
// ----------------------------------------------------------------------------
// tt_mux_ow_sel
// Picks the active project's 24-bit output slice out of the concatenated
// project output bus. The result is forced to zero while no project is
// enabled so a disabled project can never leak onto the shared pins.
//
// Build option: define MUX_CTRL_OUT_REG_EN to register the output
// (one extra cycle of latency, asynchronously reset to zero).
//
// Ports:
//   clk     in   clock (used only by the optional output register)
//   rst     in   asynchronous active-high reset
//   ow_bus  in   NUM_PROJ*OW_W project outputs, project 0 in the LSBs
//   addr    in   ADDR_W index of the active project
//   en      in   high when any project enable is asserted
//   ow_sel  out  OW_W selected output (zero when en is low)
// ----------------------------------------------------------------------------
module tt_mux_ow_sel
   import tt_mux_pkg::*;
#(
   parameter int NUM_PROJ = 16,
   parameter int ADDR_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_PROJ*OW_W-1:0] ow_bus,
   input  logic [ADDR_W-1:0]        addr,
   input  logic                     en,
   output logic [OW_W-1:0]          ow_sel
);

   logic [OW_W-1:0] sel_comb;

   // Index match per slice rather than a variable part-select, so an address
   // beyond NUM_PROJ simply yields zero instead of an out-of-range slice.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block can leave it unassigned and infer a latch.
      sel_comb = '0;
      if (en) begin
         for (int i = 0; i < NUM_PROJ; i++) begin
            if (addr == ADDR_W'(i)) begin
               sel_comb = ow_bus[i*OW_W +: OW_W];
            end
         end
      end
   end

`ifdef MUX_CTRL_OUT_REG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ow_sel <= '0;
      end else begin
         ow_sel <= sel_comb;
      end
   end
`else
   // Clock and reset only matter for the registered build.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;
   assign ow_sel         = sel_comb;
`endif

endmodule : tt_mux_ow_sel

// File: rtl/tt_mux_ctrl.sv
// ----------------------------------------------------------------------------
// tt_mux_ctrl
// Time-multiplexes one host pin set across NUM_PROJ project wrappers.
// A select request switches projects through a safe sequence:
//   OFF (every enable low, project reset held, OFF_CYCLES cycles)
//   ARM (new project enabled, reset still held, RST_CYCLES cycles)
//   RUN (project reset released).
// An out-of-range request sets the sticky err flag and parks in IDLE.
//
// Build option: MUX_CTRL_OUT_REG_EN registers ow_sel (see tt_mux_ow_sel).
//
// Ports:
//   clk          in   sole clock
//   rst          in   asynchronous active-high reset
//   sel_valid    in   select request
//   sel_addr     in   ADDR_W requested project index
//   sel_ready    out  request accepted when high together with sel_valid
//   iw_host      in   18 host bus {uio_in, ui_in, rst_n, clk}
//   iw_proj      out  18 host bus with rst_n gated by the controller
//   ena          out  NUM_PROJ one-hot project enable
//   ow_bus       in   24*NUM_PROJ project outputs, project 0 in the LSBs
//   ow_sel       out  24 output of the selected project
//   active_addr  out  ADDR_W index of the current project
//   running      out  high in RUN
//   err          out  sticky invalid-address flag
// ----------------------------------------------------------------------------
module tt_mux_ctrl
   import tt_mux_pkg::*;
#(
   parameter int NUM_PROJ   = 16,
   parameter int ADDR_W     = 4,
   parameter int RST_CYCLES = 8   // legal 1..255, bounded by the 8-bit counter
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sel_valid,
   input  logic [ADDR_W-1:0]        sel_addr,
   output logic                     sel_ready,
   input  logic [IW_W-1:0]          iw_host,
   output logic [IW_W-1:0]          iw_proj,
   output logic [NUM_PROJ-1:0]      ena,
   input  logic [NUM_PROJ*OW_W-1:0] ow_bus,
   output logic [OW_W-1:0]          ow_sel,
   output logic [ADDR_W-1:0]        active_addr,
   output logic                     running,
   output logic                     err
);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [ADDR_W-1:0]  addr_nxt;
   logic               err_nxt;
   logic               xfer;
   logic               addr_ok;
   logic               ena_on;
   logic               proj_rst_n;

   assign sel_ready  = (state == ST_IDLE) || (state == ST_RUN);
   assign xfer       = sel_valid && sel_ready;
   assign addr_ok    = (32'(sel_addr) < 32'(NUM_PROJ));
   assign ena_on     = (state == ST_ARM) || (state == ST_RUN);
   assign proj_rst_n = (state == ST_RUN);
   assign running    = proj_rst_n;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         active_addr <= '0;
         err         <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of its neighbours.
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         active_addr <= addr_nxt;
         err         <= err_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      addr_nxt  = active_addr;
      err_nxt   = err;

      unique case (state)
         ST_IDLE, ST_RUN: begin
            // A request in RUN restarts the switch sequence even for the
            // address already running, giving the project a fresh reset.
            if (xfer) begin
               cnt_nxt = '0;
               if (addr_ok) begin
                  addr_nxt  = sel_addr;
                  err_nxt   = 1'b0;
                  state_nxt = ST_OFF;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end

         ST_OFF: begin
            if (cnt == CNT_W'(OFF_CYCLES - 1)) begin
               cnt_nxt   = '0;
               state_nxt = ST_ARM;
            end else begin
               cnt_nxt   = cnt + 1'b1;
            end
         end

         ST_ARM: begin
            // Terminal count ends the phase, so the counter never wraps.
            if (cnt == CNT_W'(RST_CYCLES - 1)) begin
               cnt_nxt   = '0;
               state_nxt = ST_RUN;
            end else begin
               cnt_nxt   = cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // One-hot enable: derived from a single address so at most one bit is set
   // ------------------------------------------------------------------------
   always_comb begin
      ena = '0;
      for (int i = 0; i < NUM_PROJ; i++) begin
         ena[i] = ena_on && (active_addr == ADDR_W'(i));
      end
   end

   // Only the project reset line (bit 1) is gated; the rest pass straight on.
   assign iw_proj = {iw_host[IW_W-1:2], iw_host[1] & proj_rst_n, iw_host[0]};

   tt_mux_ow_sel #(
      .NUM_PROJ (NUM_PROJ),
      .ADDR_W   (ADDR_W)
   ) u_ow_sel (
      .clk    (clk),
      .rst    (rst),
      .ow_bus (ow_bus),
      .addr   (active_addr),
      .en     (|ena),
      .ow_sel (ow_sel)
   );

endmodule : tt_mux_ctrl

// File: tb/tb_tt_mux_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tt_mux_ctrl
// Directed bench for tt_mux_ctrl with NUM_PROJ = 16, ADDR_W = 5 (so that
// address 17 is expressible), RST_CYCLES = 8. Cycle k means "sampled 1 time
// unit after the k-th rising edge following the accepting edge".
// ----------------------------------------------------------------------------
module tb_tt_mux_ctrl;

   localparam int NUM_PROJ   = 16;
   localparam int ADDR_W     = 5;
   localparam int RST_CYCLES = 8;
   localparam int SEQ_LEN    = 2 + RST_CYCLES;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     sel_valid;
   logic [ADDR_W-1:0]        sel_addr;
   logic                     sel_ready;
   logic [17:0]              iw_host;
   logic [17:0]              iw_proj;
   logic [NUM_PROJ-1:0]      ena;
   logic [NUM_PROJ*24-1:0]   ow_bus;
   logic [23:0]              ow_sel;
   logic [ADDR_W-1:0]        active_addr;
   logic                     running;
   logic                     err;

   int errors = 0;
   int checks = 0;

   logic [23:0] slice_q [NUM_PROJ];

   tt_mux_ctrl #(
      .NUM_PROJ   (NUM_PROJ),
      .ADDR_W     (ADDR_W),
      .RST_CYCLES (RST_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sel_valid   (sel_valid),
      .sel_addr    (sel_addr),
      .sel_ready   (sel_ready),
      .iw_host     (iw_host),
      .iw_proj     (iw_proj),
      .ena         (ena),
      .ow_bus      (ow_bus),
      .ow_sel      (ow_sel),
      .active_addr (active_addr),
      .running     (running),
      .err         (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] onehot(input int a);
      logic [15:0] r;
      r = 16'd1;
      return r << a;
   endfunction

   task automatic apply_bus();
      for (int i = 0; i < NUM_PROJ; i++) ow_bus[i*24 +: 24] = slice_q[i];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [ADDR_W-1:0] a);
      sel_valid = 1'b1;
      sel_addr  = a;
      step();
      sel_valid = 1'b0;
   endtask

   // Full switch to project a, checked cycle by cycle from k=0 to RUN.
   task automatic run_seq(input logic [ADDR_W-1:0] a, input string tag);
      logic [15:0] exp_ena;
      logic        exp_run;
      accept(a);
      check($sformatf("%s_k0_err", tag), 32'(err), 32'd0);
      check($sformatf("%s_k0_addr", tag), 32'(active_addr), 32'(a));
      for (int k = 0; k <= SEQ_LEN; k++) begin
         if (k > 0) step();
         exp_ena = (k >= 2) ? onehot(int'(a)) : 16'h0000;
         exp_run = (k >= SEQ_LEN);
         check($sformatf("%s_k%0d_ena", tag, k), 32'(ena), 32'(exp_ena));
         check($sformatf("%s_k%0d_running", tag, k), 32'(running), 32'(exp_run));
         check($sformatf("%s_k%0d_ready", tag, k), 32'(sel_ready), 32'(exp_run));
         check($sformatf("%s_k%0d_rstn", tag, k), 32'(iw_proj[1]), 32'(exp_run));
         if (k == 1) check($sformatf("%s_k1_owsel", tag), 32'(ow_sel), 32'd0);
      end
      check($sformatf("%s_run_owsel", tag), 32'(ow_sel), 32'(slice_q[a]));
      check($sformatf("%s_run_iwproj", tag), 32'(iw_proj), 32'h2AAAB);
   endtask

   initial begin
      rst       = 1'b1;
      sel_valid = 1'b0;
      sel_addr  = '0;
      iw_host   = 18'h2AAAB;
      for (int i = 0; i < NUM_PROJ; i++) slice_q[i] = {8'(i + 8'h10), 16'hBEEF};
      slice_q[7] = 24'hA5C33C;
      apply_bus();

      // Reset state, observed while rst is still high.
      #2;
      check("rst_ena",     32'(ena),         32'd0);
      check("rst_addr",    32'(active_addr), 32'd0);
      check("rst_err",     32'(err),         32'd0);
      check("rst_running", 32'(running),     32'd0);
      check("rst_ready",   32'(sel_ready),   32'd1);
      check("rst_iwproj",  32'(iw_proj),     32'h2AAA9);
      check("rst_owsel",   32'(ow_sel),      32'd0);
      @(negedge clk);
      rst = 1'b0;

      // First request right after reset, then switch 3 -> 5.
      run_seq(5'd3, "sel3");
      run_seq(5'd5, "sel5");

      // Invalid address: sticky err, IDLE, project dropped, address kept.
      accept(5'd17);
      check("bad_err",     32'(err),         32'd1);
      check("bad_ena",     32'(ena),         32'd0);
      check("bad_running", 32'(running),     32'd0);
      check("bad_ready",   32'(sel_ready),   32'd1);
      check("bad_addr",    32'(active_addr), 32'd5);
      step();
      check("bad_hold_err", 32'(err), 32'd1);
      check("bad_hold_ena", 32'(ena), 32'd0);
      run_seq(5'd2, "sel2");

      // sel_valid held high: no transfer before RUN, then exactly one restart.
      sel_valid = 1'b1;
      sel_addr  = 5'd4;
      step();
      for (int k = 1; k <= SEQ_LEN; k++) begin
         step();
         if (k == SEQ_LEN - 1) begin
            check("hold_k9_running", 32'(running),   32'd0);
            check("hold_k9_ready",   32'(sel_ready), 32'd0);
         end
      end
      check("hold_k10_running", 32'(running),   32'd1);
      check("hold_k10_ready",   32'(sel_ready), 32'd1);
      step();
      sel_valid = 1'b0;
      check("hold_restart_running", 32'(running),     32'd0);
      check("hold_restart_ena",     32'(ena),         32'd0);
      check("hold_restart_ready",   32'(sel_ready),   32'd0);
      check("hold_restart_addr",    32'(active_addr), 32'd4);
      for (int k = 1; k < SEQ_LEN; k++) step();
      check("hold2_k9_running", 32'(running), 32'd0);
      step();
      check("hold2_k10_running", 32'(running), 32'd1);

      // Output selection: only project 7's slice reaches ow_sel.
      run_seq(5'd7, "sel7");
      slice_q[6] = 24'h000000;
      slice_q[8] = 24'hFFFFFF;
      apply_bus();
      step();
      check("ow_other_slices", 32'(ow_sel), 32'hA5C33C);
      slice_q[7] = 24'h5A3CC3;
      apply_bus();
      #1;
`ifdef MUX_CTRL_OUT_REG_EN
      check("ow_latency", 32'(ow_sel), 32'hA5C33C);
`else
      check("ow_latency", 32'(ow_sel), 32'h5A3CC3);
`endif
      step();
      check("ow_new_value", 32'(ow_sel), 32'h5A3CC3);

      // Reset in the middle of ARM acts before the next clock edge.
      accept(5'd6);
      for (int k = 1; k <= 4; k++) step();
      check("arm_ena", 32'(ena), 32'(onehot(6)));
      #2;
      rst = 1'b1;
      #1;
      check("midrst_ena",     32'(ena),         32'd0);
      check("midrst_rstn",    32'(iw_proj[1]),  32'd0);
      check("midrst_owsel",   32'(ow_sel),      32'd0);
      check("midrst_addr",    32'(active_addr), 32'd0);
      check("midrst_running", 32'(running),     32'd0);
      check("midrst_ready",   32'(sel_ready),   32'd1);
      @(negedge clk);
      rst = 1'b0;
      run_seq(5'd1, "post_rst_sel1");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_tt_mux_ctrl
